// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, bus widths and the per-cycle RAM grant type.
package fb_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 12;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write buffer; pushes are refused while full, pops while empty.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO never accepts, even when the head leaves on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every cycle, buffered
// pixel writes drain into the RAM in order whenever the read port is quiet.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_DEPTH   = fb_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_addr,
  output logic [15:0]       stall_cnt,
  input  logic              err_clr
);

  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);

  grant_t            grant;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              in_range;
  logic              pop;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign wr_ready = !fifo_full && !reset;
  assign accept   = wr_valid && wr_ready;
  assign in_range = (wr_addr < DEPTH_A);
  assign pop      = (grant == GNT_WRITE);
  assign head_addr = head[EW-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && in_range),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Grant is decided fresh every cycle; reset holds the RAM port quiet.
  always_comb begin
    grant = GNT_IDLE;
    if (reset)            grant = GNT_IDLE;
    else if (rd_req)      grant = GNT_READ;
    else if (!fifo_empty) grant = GNT_WRITE;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_READ: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= (grant == GNT_READ);
  end

  assign rd_data = (rd_valid && !reset) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset || err_clr)          err_addr <= 1'b0;
    else if (accept && !in_range)  err_addr <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || err_clr)
      stall_cnt <= '0;
    else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port RAM.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        err_addr;
  logic [15:0] stall_cnt;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  logic [11:0] ram [0:131071];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  fb_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err_addr  (err_addr),
    .stall_cnt (stall_cnt),
    .err_clr   (err_clr)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    next();
    reset = 1'b1; rd_req = 1'b1; wr_valid = 1'b1; wr_addr = 17'd1; wr_data = 12'h111;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, wr_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_forced en_we_rdy got=%b exp=000", {mem_en, mem_we, wr_ready});
    end
    checks++;
    if ({rd_valid, rd_data, err_addr, stall_cnt} !== '0) begin
      failures++; $display("FAIL reset_regs rv=%b rd=%h err=%b stall=%0d exp all 0", rd_valid, rd_data, err_addr, stall_cnt);
    end
    next();
    reset = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", wr_ready);
    end
  endtask

  task automatic test_single_write();
    next();
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 12'hABC;
    @(negedge clk);
    checks++;
    if ({wr_ready, mem_en} !== 2'b10) begin
      failures++; $display("FAIL single_accept rdy_en got=%b exp=10", {wr_ready, mem_en});
    end
    next();
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 17'd5, 12'hABC}) begin
      failures++; $display("FAIL single_write en=%b we=%b addr=%0d data=%h exp 1 1 5 abc", mem_en, mem_we, mem_addr, mem_wdata);
    end
    next();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL single_empty mem_en got=%b exp=0", mem_en);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      next();
      wr_valid = (i < 5);
      wr_addr  = 17'(300 + i);
      wr_data  = 12'(12'h500 + i);
      @(negedge clk);
      if (i < 5) begin
        checks++;
        if (wr_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, wr_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'(300 + i - 1), 12'(12'h500 + i - 1)}) begin
          failures++; $display("FAIL b2b_write[%0d] we=%b addr=%0d data=%h exp addr=%0d", i, mem_we, mem_addr, mem_wdata, 300 + i - 1);
        end
      end
    end
    next();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL b2b_drained mem_en got=%b exp=0", mem_en);
    end
  endtask

  task automatic test_read_priority();
    next(); err_clr = 1'b1;
    next(); err_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      next();
      rd_req   = 1'b1;
      rd_addr  = 17'(k);
      wr_valid = (k < 6);
      wr_addr  = 17'(200 + k);
      wr_data  = 12'(12'h0A0 + k);
      @(negedge clk);
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 17'(k)}) begin
        failures++; $display("FAIL prio_read[%0d] en=%b we=%b addr=%0d exp 1 0 %0d", k, mem_en, mem_we, mem_addr, k);
      end
      if (k < 6) begin
        checks++;
        if (wr_ready !== (k < 4)) begin
          failures++; $display("FAIL prio_ready[%0d] got=%b exp=%b", k, wr_ready, (k < 4));
        end
      end
      if (k > 0) begin
        checks++;
        if (rd_valid !== 1'b1) begin
          failures++; $display("FAIL prio_rd_valid[%0d] got=%b exp=1", k, rd_valid);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      next();
      rd_req = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (stall_cnt !== 16'd2) begin
          failures++; $display("FAIL prio_stall_cnt got=%0d exp=2", stall_cnt);
        end
      end
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 17'(200 + i), 12'(12'h0A0 + i)}) begin
        failures++; $display("FAIL prio_retire[%0d] we=%b addr=%0d data=%h exp addr=%0d", i, mem_we, mem_addr, mem_wdata, 200 + i);
      end
    end
    next();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL prio_drained mem_en got=%b exp=0", mem_en);
    end
  endtask

  task automatic test_read_after_write();
    next(); wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 12'h123;
    next(); wr_valid = 1'b0;
    next(); rd_req = 1'b1; rd_addr = 17'd100;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, rd_valid} !== {2'b10, 17'd100, 12'h000, 1'b0}) begin
      failures++; $display("FAIL raw_issue en=%b we=%b addr=%0d wd=%h rv=%b", mem_en, mem_we, mem_addr, mem_wdata, rd_valid);
    end
    next(); rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'h123}) begin
      failures++; $display("FAIL raw_data rv=%b data=%h exp 1 123", rd_valid, rd_data);
    end
    next();
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data} !== 13'd0) begin
      failures++; $display("FAIL raw_after rv=%b data=%h exp 0 000", rd_valid, rd_data);
    end
  endtask

  task automatic test_addr_error();
    next(); wr_valid = 1'b1; wr_addr = 17'd76800; wr_data = 12'h007;
    @(negedge clk);
    checks++;
    if ({wr_ready, err_addr} !== 2'b10) begin
      failures++; $display("FAIL err_accept rdy_err got=%b exp=10", {wr_ready, err_addr});
    end
    next(); wr_addr = 17'd76799; wr_data = 12'h3C3;
    @(negedge clk);
    checks++;
    if ({err_addr, mem_en} !== 2'b10) begin
      failures++; $display("FAIL err_set err_en got=%b exp=10", {err_addr, mem_en});
    end
    next(); wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'd76799, 12'h3C3}) begin
      failures++; $display("FAIL err_last_word we=%b addr=%0d data=%h exp 1 76799 3c3", mem_we, mem_addr, mem_wdata);
    end
    next(); err_clr = 1'b1; wr_valid = 1'b1; wr_addr = 17'd76801;
    @(negedge clk);
    next(); err_clr = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({err_addr, mem_en} !== 2'b00) begin
      failures++; $display("FAIL err_clr_wins err_en got=%b exp=00", {err_addr, mem_en});
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      next();
      rd_req = 1'b1; rd_addr = 17'd100;
      wr_valid = 1'b1; wr_addr = 17'(400 + i); wr_data = 12'(i + 1);
    end
    next();
    reset = 1'b1; rd_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, wr_ready, rd_data} !== 15'd0) begin
      failures++; $display("FAIL rst_burst_forced en=%b we=%b rdy=%b rd=%h exp all 0", mem_en, mem_we, wr_ready, rd_data);
    end
    next();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_ready, rd_valid, mem_en, stall_cnt} !== {3'b100, 16'd0}) begin
      failures++; $display("FAIL rst_burst_release rdy=%b rv=%b en=%b stall=%0d exp 1 0 0 0", wr_ready, rd_valid, mem_en, stall_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      next();
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin
        failures++; $display("FAIL rst_burst_no_write[%0d] mem_we got=%b exp=0", i, mem_we);
      end
    end
  endtask

  task automatic test_stall_saturation();
    next(); err_clr = 1'b1;
    next(); err_clr = 1'b0;
    for (int i = 0; i <= 65550; i++) begin
      next();
      rd_req = 1'b1; wr_valid = 1'b1;
      wr_addr = 17'(500 + (i % 8)); wr_data = 12'h0F0;
      @(negedge clk);
      if (i == 65538) begin
        checks++;
        if (stall_cnt !== 16'd65534) begin
          failures++; $display("FAIL stall_pre_sat got=%0d exp=65534", stall_cnt);
        end
      end else if (i == 65539) begin
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
          failures++; $display("FAIL stall_at_sat got=%h exp=ffff", stall_cnt);
        end
      end else if (i == 65550) begin
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
          failures++; $display("FAIL stall_hold got=%h exp=ffff", stall_cnt);
        end
      end
    end
    next(); err_clr = 1'b1;
    next(); err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL stall_clr_wins got=%0d exp=0", stall_cnt);
    end
    next();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd1) begin
      failures++; $display("FAIL stall_restart got=%0d exp=1", stall_cnt);
    end
    next(); reset = 1'b1; rd_req = 1'b0; wr_valid = 1'b0;
    next(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; err_clr = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_priority();
    test_read_after_write();
    test_addr_error();
    test_reset_mid_burst();
    test_stall_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
